playback_ctrl: RTL and testbench
================================

# playback_ctrl

Playback controller sitting directly downstream of the keyboard decoder. It consumes the decoder's per-letter command levels (D, E, B, F, R) and runs play/pause/direction/restart control. It walks a word address through sample memory with a request/acknowledge read handshake and emits one 16-bit audio sample per sample tick, two samples per 32-bit word.

## Interface
- ADDR_W, 23, width of word address
- LAST_ADDR, 23'h7FFFF, highest word address; wrap point
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_d  in  1  decoder level: pause
- key_e  in  1  decoder level: play
- key_b  in  1  decoder level: backward
- key_f  in  1  decoder level: forward
- key_r  in  1  decoder level: restart
- sample_tick  in  1  one-cycle strobe at audio sample rate
- rd_req  out  1  read request, held until rd_ack
- rd_addr  out  ADDR_W  word address for current request
- rd_ack  in  1  one-cycle strobe; rd_data valid in same cycle
- rd_data  in  32  memory word: [15:0] first sample, [31:16] second sample
- audio_out  out  16  current sample, held between updates
- sample_valid  out  1  one-cycle pulse when audio_out updates
- playing  out  1  1 = playing, 0 = paused
- forward  out  1  1 = forward, 0 = backward

## Operation
- Command detection:
  - Each key input is registered into a prev register that resets to 0.
  - Event = key & ~prev.
  - A key high at reset release produces an event in the first cycle.
- Command priority within one cycle:
  - R first, applied after any play/direction change in the same cycle.
  - D beats E.
  - F beats B.
- Command effects:
  - E sets playing=1; D sets playing=0.
  - F sets forward=1; B sets forward=0.
  - R sets addr to 0 if forward, or LAST_ADDR if backward, using the post-update direction. It also clears half.
- State machine: IDLE, FETCH.
  - IDLE, playing=1, sample_tick, half=0 -> FETCH, rd_req=1.
  - IDLE, playing=1, sample_tick, half=1 -> output the second half of the latched word (high half if forward, low half if backward). Then advance addr, clear half, stay IDLE.
  - FETCH: hold rd_req and rd_addr stable until rd_ack.
  - On rd_ack: latch rd_data and output the first half (low half if forward, high half if backward). Set half=1, deassert rd_req, go to IDLE.
- Advance rules:
  - Forward: addr+1, with LAST_ADDR -> 0.
  - Backward: addr-1, with 0 -> LAST_ADDR.
- Ignored events:
  - sample_tick in FETCH is ignored.
  - sample_tick while playing=0 is ignored.
- Direction change with half=1: the remaining half still comes from the latched word in its original order. The advance uses the new direction.
- Pause during FETCH: the fetch completes and its first sample is output, then no further output occurs.
- Restart during FETCH:
  - The handshake is never aborted; a pending flag is set.
  - On rd_ack the word is discarded: no audio_out change, no sample_valid.
  - The restart address is then loaded, half=0, and the machine goes to IDLE.

## Timing
- Reset values: rd_req=0, rd_addr=0, audio_out=0, sample_valid=0, playing=0, forward=1, half=0, state IDLE, restart pending=0.
- Key event at edge N (key high, prev low): playing and forward reflect the command after edge N.
- sample_tick sampled at edge N in IDLE with half=0: rd_req=1 after edge N.
- rd_ack sampled at edge M: audio_out and sample_valid=1 after edge M, and rd_req=0 after edge M. Minimum tick-to-sample latency is 2 cycles.
- Second-half sample: audio_out and sample_valid after the tick edge (1 cycle), with addr advanced at the same edge.
- sample_valid is never high for two consecutive cycles.
- rd_addr changes only while rd_req=0.

## Test plan
- Reset, press E, feed ticks with a zero-wait ack and rd_data=32'hBBBB_AAAA at addr 0 -> audio_out sequence AAAA then BBBB, then rd_addr=1 on the next request.
- Press B after the first sample of word 5 (rd_data=32'h2222_1111) -> 1111, 2222, then a request for addr 4. The next word's high half is output first.
- Forward at addr LAST_ADDR second half -> next rd_addr=0. Backward at addr 0 -> next rd_addr=LAST_ADDR.
- Press R while in FETCH with ack delayed 5 cycles -> rd_req held 5 cycles, no sample_valid on that ack, next rd_addr=0 (forward).
- Press D, then ticks -> no rd_req and audio_out holds. Pulse D and E together -> playing=0. Pulse F and B together -> forward=1.
- Assert reset mid-FETCH -> all outputs return to reset values immediately, asynchronously.

Source files
------------

// File: rtl/playback_ctrl.sv
// Playback controller: decodes key edges into play/pause/direction/restart and
// streams 16-bit samples from 32-bit memory words via a req/ack read handshake.
module playback_ctrl #(
  parameter int unsigned           ADDR_W    = 23,
  parameter logic [ADDR_W-1:0]     LAST_ADDR = 23'h7FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_d,
  input  logic              key_e,
  input  logic              key_b,
  input  logic              key_f,
  input  logic              key_r,
  input  logic              sample_tick,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [31:0]       rd_data,
  output logic [15:0]       audio_out,
  output logic              sample_valid,
  output logic              playing,
  output logic              forward
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]        state;
  logic [4:0]        keys, prev, ev;
  logic [ADDR_W-1:0] addr, restart_addr, next_addr;
  logic [31:0]       word;
  logic              word_fwd;
  logic              half;
  logic              pending;
  logic              playing_n, forward_n;

  assign keys    = {key_r, key_f, key_b, key_e, key_d};
  assign ev      = keys & ~prev;
  assign rd_addr = addr;

  always_comb begin
    playing_n = playing;
    if (ev[0])      playing_n = 1'b0;
    else if (ev[1]) playing_n = 1'b1;

    forward_n = forward;
    if (ev[3])      forward_n = 1'b1;
    else if (ev[2]) forward_n = 1'b0;

    restart_addr = forward_n ? '0 : LAST_ADDR;

    if (forward_n) next_addr = (addr == LAST_ADDR) ? '0 : addr + 1'b1;
    else           next_addr = (addr == '0) ? LAST_ADDR : addr - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      prev         <= '0;
      addr         <= '0;
      word         <= '0;
      word_fwd     <= 1'b1;
      half         <= 1'b0;
      pending      <= 1'b0;
      rd_req       <= 1'b0;
      audio_out    <= '0;
      sample_valid <= 1'b0;
      playing      <= 1'b0;
      forward      <= 1'b1;
    end else begin
      prev         <= keys;
      playing      <= playing_n;
      forward      <= forward_n;
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A restart in IDLE takes effect immediately; a coincident tick is dropped.
          if (ev[4]) begin
            addr <= restart_addr;
            half <= 1'b0;
          end else if (playing && sample_tick) begin
            if (!half) begin
              state  <= FETCH;
              rd_req <= 1'b1;
            end else begin
              // Second half keeps the latched word's order; advance uses current direction.
              audio_out    <= word_fwd ? word[31:16] : word[15:0];
              sample_valid <= 1'b1;
              addr         <= next_addr;
              half         <= 1'b0;
            end
          end
        end
        FETCH: begin
          if (rd_ack) begin
            rd_req <= 1'b0;
            state  <= IDLE;
            if (pending || ev[4]) begin
              addr    <= restart_addr;
              half    <= 1'b0;
              pending <= 1'b0;
            end else begin
              word         <= rd_data;
              word_fwd     <= forward_n;
              audio_out    <= forward_n ? rd_data[15:0] : rd_data[31:16];
              sample_valid <= 1'b1;
              half         <= 1'b1;
            end
          end else if (ev[4]) begin
            pending <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_playback_ctrl.sv
// Directed self-checking bench for playback_ctrl: playback order, direction
// changes, address wrap, restart during fetch, pause and async reset.
module tb_playback_ctrl;

  localparam logic [22:0] LAST = 23'h7FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_d = 1'b0, key_e = 1'b0, key_b = 1'b0, key_f = 1'b0, key_r = 1'b0;
  logic        sample_tick = 1'b0;
  logic        rd_req;
  logic [22:0] rd_addr;
  logic        rd_ack = 1'b0;
  logic [31:0] rd_data = '0;
  logic [15:0] audio_out;
  logic        sample_valid;
  logic        playing;
  logic        forward;

  int errors = 0;
  int checks = 0;

  playback_ctrl #(.ADDR_W(23), .LAST_ADDR(23'h7FFFF)) dut (
    .clk(clk), .reset(reset),
    .key_d(key_d), .key_e(key_e), .key_b(key_b), .key_f(key_f), .key_r(key_r),
    .sample_tick(sample_tick),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .audio_out(audio_out), .sample_valid(sample_valid),
    .playing(playing), .forward(forward)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"}, 32'(rd_req), 32'd0);
    chk({tag, "_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_audio"}, 32'(audio_out), 32'd0);
    chk({tag, "_valid"}, 32'(sample_valid), 32'd0);
    chk({tag, "_playing"}, 32'(playing), 32'd0);
    chk({tag, "_forward"}, 32'(forward), 32'd1);
  endtask

  // Tick in IDLE with half=0, hold ack off for 'delay' cycles, then deliver the word.
  task automatic fetch(input logic [22:0] exp_addr, input logic [31:0] data,
                       input int delay, input logic [15:0] exp_audio);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("fetch_req", 32'(rd_req), 32'd1);
    chk("fetch_addr", 32'(rd_addr), 32'(exp_addr));
    for (int i = 0; i < delay; i++) begin
      step();
      chk("fetch_req_held", 32'(rd_req), 32'd1);
    end
    rd_ack  = 1'b1;
    rd_data = data;
    step();
    rd_ack  = 1'b0;
    chk("first_valid", 32'(sample_valid), 32'd1);
    chk("first_audio", 32'(audio_out), 32'(exp_audio));
    chk("first_req_drop", 32'(rd_req), 32'd0);
    step();
    chk("first_valid_pulse", 32'(sample_valid), 32'd0);
  endtask

  task automatic second(input logic [15:0] exp_audio);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("second_valid", 32'(sample_valid), 32'd1);
    chk("second_audio", 32'(audio_out), 32'(exp_audio));
    chk("second_no_req", 32'(rd_req), 32'd0);
    step();
    chk("second_valid_pulse", 32'(sample_valid), 32'd0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk_reset_state("reset");
    reset = 1'b0;
    step();

    // Play
    key_e = 1'b1; step(); chk("play_on", 32'(playing), 32'd1);
    key_e = 1'b0; step();

    // Word 0 forward: low half then high half
    fetch(23'd0, 32'hBBBB_AAAA, 0, 16'hAAAA);
    second(16'hBBBB);

    // Words 1..4 forward
    for (int a = 1; a <= 4; a++) begin
      fetch(23'(a), {16'h1000 + 16'(a), 16'h2000 + 16'(a)}, 0, 16'h2000 + 16'(a));
      second(16'h1000 + 16'(a));
    end

    // Word 5: reverse after first sample; remaining half keeps original order
    fetch(23'd5, 32'h2222_1111, 0, 16'h1111);
    key_b = 1'b1; step(); chk("dir_back", 32'(forward), 32'd0);
    key_b = 1'b0; step();
    second(16'h2222);
    fetch(23'd4, 32'h4444_3333, 0, 16'h4444);
    second(16'h3333);

    // Backward down to 0, then wrap to LAST
    for (int a = 3; a >= 0; a--) begin
      fetch(23'(a), {16'h1000 + 16'(a), 16'h2000 + 16'(a)}, 0, 16'h1000 + 16'(a));
      second(16'h2000 + 16'(a));
    end
    fetch(LAST, 32'h6666_5555, 0, 16'h6666);

    // Forward at LAST second half: wraps to 0
    key_f = 1'b1; step(); chk("dir_fwd", 32'(forward), 32'd1);
    key_f = 1'b0; step();
    second(16'h5555);
    fetch(23'd0, 32'h8888_7777, 0, 16'h7777);
    second(16'h8888);
    fetch(23'd1, 32'h1001_2001, 0, 16'h2001);
    second(16'h1001);

    // Restart during a 5-cycle-delayed fetch of addr 2
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    chk("rst_fetch_req", 32'(rd_req), 32'd1);
    chk("rst_fetch_addr", 32'(rd_addr), 32'd2);
    key_r = 1'b1; step(); key_r = 1'b0;
    chk("rst_req_held", 32'(rd_req), 32'd1);
    chk("rst_addr_held", 32'(rd_addr), 32'd2);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_req_held", 32'(rd_req), 32'd1);
    end
    rd_ack = 1'b1; rd_data = 32'hDEAD_BEEF; step(); rd_ack = 1'b0;
    chk("rst_no_valid", 32'(sample_valid), 32'd0);
    chk("rst_audio_hold", 32'(audio_out), 32'h1001);
    chk("rst_req_drop", 32'(rd_req), 32'd0);
    step();
    fetch(23'd0, 32'h0BAD_F00D, 0, 16'hF00D);
    second(16'h0BAD);

    // Pause: ticks ignored
    key_d = 1'b1; step(); chk("pause", 32'(playing), 32'd0);
    key_d = 1'b0; step();
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    chk("pause_no_req", 32'(rd_req), 32'd0);
    chk("pause_no_valid", 32'(sample_valid), 32'd0);
    chk("pause_audio_hold", 32'(audio_out), 32'h0BAD);
    step();

    // Simultaneous commands
    key_e = 1'b1; step(); chk("play_again", 32'(playing), 32'd1);
    key_e = 1'b0; step();
    key_d = 1'b1; key_e = 1'b1; step(); chk("d_beats_e", 32'(playing), 32'd0);
    key_d = 1'b0; key_e = 1'b0; step();
    key_b = 1'b1; step(); chk("back_again", 32'(forward), 32'd0);
    key_b = 1'b0; step();
    key_f = 1'b1; key_b = 1'b1; step(); chk("f_beats_b", 32'(forward), 32'd1);
    key_f = 1'b0; key_b = 1'b0; step();

    // Async reset in the middle of a fetch
    key_b = 1'b1; step(); key_b = 1'b0;
    key_e = 1'b1; step(); key_e = 1'b0;
    step();
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    chk("pre_reset_req", 32'(rd_req), 32'd1);
    chk("pre_reset_addr", 32'(rd_addr), 32'd1);
    #2 reset = 1'b1;
    #1 chk_reset_state("async_reset");
    step();
    reset = 1'b0;
    step();
    chk("post_reset_req", 32'(rd_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
